// File: rtl/battle_fsm.sv
// Battleship game controller: ship placement, shot exchange with a peer, win/lose detection.
// Optional BOARD_CLEAR_EN: start_btn in WIN/LOSE sweeps both boards to EMPTY and returns to IDLE.
module battle_fsm #(
   parameter int unsigned SHIPS_NUMBER = 10,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned CTR_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_btn,
   output logic              start_btn_en,
   input  logic [ADDR_W-1:0] my_grid_cords,
   input  logic [ADDR_W-1:0] en_grid_cords,
   output logic [ADDR_W-1:0] my_mem_addr,
   output logic [ADDR_W-1:0] en_mem_addr,
   input  logic [1:0]        my_mem_data_in,
   input  logic [1:0]        en_mem_data_in,
   output logic [1:0]        my_mem_data_out,
   output logic [1:0]        en_mem_data_out,
   output logic              my_mem_w_nr,
   output logic              en_mem_w_nr,
   input  logic              ready2,
   input  logic              hit2,
   output logic              ready1,
   output logic              hit1,
   input  logic [ADDR_W-1:0] ship_cords_in,
   output logic [ADDR_W-1:0] ship_cords_out,
   output logic [CTR_W-1:0]  my_ctr,
   output logic [CTR_W-1:0]  en_ctr,
   output logic [3:0]        state_out
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      PL_RD      = 4'd1,
      PL_CHK     = 4'd2,
      PL_WR      = 4'd3,
      WAIT_ENEMY = 4'd4,
      WAIT_SHOT  = 4'd5,
      RD         = 4'd6,
      CHK        = 4'd7,
      ANSWER     = 4'd8,
      SHOT       = 4'd9,
      WAIT_ANS   = 4'd10,
      SAVE       = 4'd11,
      WIN        = 4'd12,
      LOSE       = 4'd13,
      CLEAR      = 4'd14
   } state_t;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      MYSHIP = 2'b01,
      MISS   = 2'b10,
      HIT    = 2'b11
   } cell_t;

   localparam logic [ADDR_W-1:0] NO_SEL = '1;
   localparam logic [CTR_W-1:0]  SHIPS  = CTR_W'(SHIPS_NUMBER);

   state_t state;

   // Enemy board contents are never consulted; the port stays for interface compatibility.
   logic unused_en_rd;
   assign unused_en_rd = ^en_mem_data_in;

   assign state_out = state;

   function automatic logic [CTR_W-1:0] dec_sat(input logic [CTR_W-1:0] v);
      return (v == '0) ? '0 : v - CTR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         my_ctr          <= SHIPS;
         en_ctr          <= SHIPS;
         my_mem_addr     <= '0;
         en_mem_addr     <= '0;
         my_mem_data_out <= '0;
         en_mem_data_out <= '0;
         my_mem_w_nr     <= 1'b0;
         en_mem_w_nr     <= 1'b0;
         ready1          <= 1'b0;
         hit1            <= 1'b0;
         ship_cords_out  <= '0;
         start_btn_en    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (my_grid_cords != NO_SEL && my_ctr != '0) begin
                  my_mem_addr <= my_grid_cords;
                  my_mem_w_nr <= 1'b0;
                  state       <= PL_RD;
               end else if (start_btn && my_ctr == '0) begin
                  ready1       <= 1'b1;
                  hit1         <= 1'b0;
                  my_ctr       <= SHIPS;
                  en_ctr       <= SHIPS;
                  start_btn_en <= 1'b0;
                  state        <= ready2 ? WAIT_ENEMY : WAIT_SHOT;
               end
            end

            PL_RD: state <= PL_CHK;

            PL_CHK: begin
               if (my_mem_data_in == EMPTY) begin
                  my_mem_data_out <= MYSHIP;
                  my_mem_w_nr     <= 1'b1;
                  my_ctr          <= dec_sat(my_ctr);
               end else begin
                  my_mem_w_nr <= 1'b0;
               end
               state <= PL_WR;
            end

            // Wait for the cursor to leave so a held selection places only once.
            PL_WR: begin
               my_mem_w_nr <= 1'b0;
               en_mem_w_nr <= 1'b0;
               if (my_grid_cords == NO_SEL)
                  state <= IDLE;
            end

            WAIT_ENEMY: begin
               if (my_ctr == '0) begin
                  state <= LOSE;
               end else if (en_ctr == '0) begin
                  state <= WIN;
               end else if (hit2 && ready2) begin
                  my_mem_addr <= ship_cords_in;
                  ready1      <= 1'b0;
                  state       <= RD;
               end else begin
                  ready1 <= 1'b1;
                  hit1   <= 1'b0;
               end
            end

            RD: state <= CHK;

            CHK: begin
               if (my_mem_data_in == MYSHIP) begin
                  hit1            <= 1'b1;
                  my_mem_data_out <= HIT;
                  my_ctr          <= dec_sat(my_ctr);
               end else if (my_mem_data_in == HIT) begin
                  hit1            <= 1'b1;
                  my_mem_data_out <= HIT;
               end else begin
                  hit1            <= 1'b0;
                  my_mem_data_out <= MISS;
               end
               ready1      <= 1'b1;
               my_mem_w_nr <= 1'b1;
               state       <= ANSWER;
            end

            ANSWER: begin
               my_mem_w_nr <= 1'b0;
               if (ready2) begin
                  hit1  <= 1'b0;
                  state <= WAIT_SHOT;
               end
            end

            WAIT_SHOT: begin
               ready1 <= 1'b1;
               if (en_grid_cords != NO_SEL) begin
                  ship_cords_out <= en_grid_cords;
                  hit1           <= 1'b1;
                  state          <= SHOT;
               end
            end

            SHOT: state <= WAIT_ANS;

            WAIT_ANS: begin
               if (ready2) begin
                  en_mem_addr <= ship_cords_out;
                  en_mem_w_nr <= 1'b1;
                  if (hit2) begin
                     en_mem_data_out <= HIT;
                     en_ctr          <= dec_sat(en_ctr);
                  end else begin
                     en_mem_data_out <= MISS;
                  end
                  state <= SAVE;
               end
            end

            SAVE: begin
               if (ready2) begin
                  hit1        <= 1'b0;
                  en_mem_w_nr <= 1'b0;
                  state       <= (my_ctr == '0) ? LOSE : WAIT_ENEMY;
               end
            end

`ifdef BOARD_CLEAR_EN
            WIN, LOSE: begin
               if (start_btn) begin
                  my_mem_addr     <= '0;
                  en_mem_addr     <= '0;
                  my_mem_data_out <= EMPTY;
                  en_mem_data_out <= EMPTY;
                  my_mem_w_nr     <= 1'b1;
                  en_mem_w_nr     <= 1'b1;
                  state           <= CLEAR;
               end
            end

            // One cell of each board per cycle; the last address written leaves for IDLE.
            CLEAR: begin
               if (my_mem_addr == NO_SEL) begin
                  my_mem_w_nr  <= 1'b0;
                  en_mem_w_nr  <= 1'b0;
                  my_ctr       <= SHIPS;
                  en_ctr       <= SHIPS;
                  start_btn_en <= 1'b1;
                  state        <= IDLE;
               end else begin
                  my_mem_addr <= my_mem_addr + ADDR_W'(1);
                  en_mem_addr <= en_mem_addr + ADDR_W'(1);
               end
            end
`else
            WIN, LOSE: state <= state;
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule
